// File: rtl/game_score_pkg.sv
// Shared types and constants for the scoring unit: FSM states, BCD line points, line cap.
package tetris;
  typedef enum logic [1:0] {eIdle, eAdd, eFinal, eOver} score_state_e;

  // BCD points per report, indexed by eliminated lines - 1
  localparam logic [3:0][15:0] line_points_c = {16'h1200, 16'h0300, 16'h0100, 16'h0040};
  localparam int lines_max_c = 999;
endpackage

// File: rtl/game_score_if.sv
// Plate/controller-facing bundle of the scoring unit; master drives reports, slave is the scorer.
interface game_score_if #(parameter int digits_p = 6);
  logic                  clear_i;
  logic [2:0]            lines_i;
  logic                  lines_v_i;
  logic                  lose_i;
  logic                  busy_o;
  logic                  overflow_o;
  logic                  game_over_o;
  logic [4*digits_p-1:0] score_bcd_o;
  logic [4*digits_p-1:0] high_score_bcd_o;
  logic [9:0]            lines_o;
  logic [3:0]            level_o;
  logic [7:0]            gravity_period_o;

  modport master (
    output clear_i, lines_i, lines_v_i, lose_i,
    input  busy_o, overflow_o, game_over_o, score_bcd_o, high_score_bcd_o,
           lines_o, level_o, gravity_period_o
  );
  modport slave (
    input  clear_i, lines_i, lines_v_i, lose_i,
    output busy_o, overflow_o, game_over_o, score_bcd_o, high_score_bcd_o,
           lines_o, level_o, gravity_period_o
  );
endinterface

// File: rtl/game_score_bcd_add.sv
// Combinational ripple BCD adder; carry out flags a result beyond all-9s.
module bcd_add #(
  parameter int digits_p = 6
) (
  input  logic [4*digits_p-1:0] a_i,
  input  logic [4*digits_p-1:0] b_i,
  output logic [4*digits_p-1:0] sum_o,
  output logic                  carry_o
);
  logic [4:0] dig;
  logic       c;

  always_comb begin
    c     = 1'b0;
    dig   = '0;
    sum_o = '0;
    for (int i = 0; i < digits_p; i++) begin
      dig = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, c};
      if (dig > 5'd9) begin
        dig = dig + 5'd6;
        c   = 1'b1;
      end else begin
        c   = 1'b0;
      end
      sum_o[4*i +: 4] = dig[3:0];
    end
    carry_o = c;
  end
endmodule

// File: rtl/game_score.sv
// BCD score, lines, level and gravity period from plate reports; one add of the base per cycle,
// one pending report buffered. SCORE_HIGH_SCORE_EN adds the high-score register.
module game_score
  import tetris::*;
#(
  parameter int digits_p          = 6,
  parameter int lines_per_level_p = 10,
  parameter int level_max_p       = 15,
  parameter int base_period_p     = 48,
  parameter int period_step_p     = 3,
  parameter int period_min_p      = 2
) (
  input logic        clk_i,
  input logic        reset_i,
  game_score_if.slave bus
);
  localparam int W = 4 * digits_p;

  score_state_e st_q;
  logic [W-1:0] score_q, base_q, pbase_q, sum_d;
  logic [4:0]   cnt_q, pcnt_q, rpt_cnt_d;
  logic         pend_q, ovf_q, lose_q, lose_pend_q, carry_d;
  logic [9:0]   lines_q, lines_d;
  logic [3:0]   level_q, level_d;
  logic [7:0]   win_q, win_d, grav_q, grav_d;
  logic [2:0]   n_d;
  logic [10:0]  lsum_d;
  logic [W-1:0] rpt_base_d;
  logic         rpt_vld_d, take_d, drop_d, lose_rise_d;
  int           per_d;

  always_comb begin
    n_d         = (bus.lines_i > 3'd4) ? 3'd4 : bus.lines_i;
    rpt_vld_d   = bus.lines_v_i && (n_d != 3'd0) && (st_q == eIdle || st_q == eAdd);
    drop_d      = rpt_vld_d && (st_q == eAdd) && pend_q;
    take_d      = rpt_vld_d && !drop_d;
    rpt_base_d  = W'(line_points_c[2'(n_d - 3'd1)]);
    rpt_cnt_d   = {1'b0, level_q} + 5'd1;
    lose_rise_d = bus.lose_i && !lose_q;

    lsum_d  = {1'b0, lines_q} + {8'b0, n_d};
    lines_d = (lsum_d > 11'(lines_max_c)) ? 10'(lines_max_c) : lsum_d[9:0];

    // Step one line at a time so any lines_per_level_p wraps correctly
    level_d = level_q;
    win_d   = win_q;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n_d)) begin
        if (win_d == 8'(lines_per_level_p - 1)) begin
          win_d = '0;
          if (level_d != 4'(level_max_p)) level_d = level_d + 4'd1;
        end else begin
          win_d = win_d + 8'd1;
        end
      end
    end

    per_d = base_period_p - int'(level_q) * period_step_p;
    if (per_d < period_min_p) per_d = period_min_p;
    grav_d = 8'(per_d);
  end

  bcd_add #(.digits_p(digits_p)) u_add (
    .a_i    (score_q),
    .b_i    (base_q),
    .sum_o  (sum_d),
    .carry_o(carry_d)
  );

`ifdef SCORE_HIGH_SCORE_EN
  logic [W-1:0] hs_q;
  assign bus.high_score_bcd_o = hs_q;
`else
  assign bus.high_score_bcd_o = '0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q        <= eIdle;
      score_q     <= '0;
      base_q      <= '0;
      pbase_q     <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lose_q      <= 1'b0;
      lose_pend_q <= 1'b0;
      lines_q     <= '0;
      level_q     <= '0;
      win_q       <= '0;
      grav_q      <= 8'(base_period_p);
`ifdef SCORE_HIGH_SCORE_EN
      hs_q        <= '0;
`endif
    end else begin
      lose_q <= bus.lose_i;
      grav_q <= grav_d;
      if (bus.clear_i) begin
        st_q        <= eIdle;
        score_q     <= '0;
        cnt_q       <= '0;
        pend_q      <= 1'b0;
        ovf_q       <= 1'b0;
        lose_pend_q <= 1'b0;
        lines_q     <= '0;
        level_q     <= '0;
        win_q       <= '0;
      end else begin
        if (lose_rise_d) lose_pend_q <= 1'b1;
        if (drop_d) ovf_q <= 1'b1;
        if (take_d) begin
          lines_q <= lines_d;
          level_q <= level_d;
          win_q   <= win_d;
        end
        case (st_q)
          eIdle: begin
            if (take_d) begin
              base_q <= rpt_base_d;
              cnt_q  <= rpt_cnt_d;
              st_q   <= eAdd;
            end else if (lose_pend_q || lose_rise_d) begin
              lose_pend_q <= 1'b0;
              st_q        <= eFinal;
            end
          end
          eAdd: begin
            score_q <= carry_d ? {digits_p{4'h9}} : sum_d;
            cnt_q   <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              // Chain straight into the next report so busy never dips
              if (pend_q) begin
                base_q <= pbase_q;
                cnt_q  <= pcnt_q;
                pend_q <= 1'b0;
              end else if (take_d) begin
                base_q <= rpt_base_d;
                cnt_q  <= rpt_cnt_d;
              end else if (lose_pend_q || lose_rise_d) begin
                lose_pend_q <= 1'b0;
                st_q        <= eFinal;
              end else begin
                st_q <= eIdle;
              end
            end else if (take_d) begin
              pend_q  <= 1'b1;
              pbase_q <= rpt_base_d;
              pcnt_q  <= rpt_cnt_d;
            end
          end
          eFinal: begin
`ifdef SCORE_HIGH_SCORE_EN
            if (score_q > hs_q) hs_q <= score_q;
`endif
            st_q <= eOver;
          end
          eOver: st_q <= eOver;
          default: st_q <= eIdle;
        endcase
      end
    end
  end

  assign bus.busy_o           = (st_q == eAdd);
  assign bus.overflow_o       = ovf_q;
  assign bus.game_over_o      = (st_q == eOver);
  assign bus.score_bcd_o      = score_q;
  assign bus.lines_o          = lines_q;
  assign bus.level_o          = level_q;
  assign bus.gravity_period_o = grav_q;
endmodule

// File: doc/game_score.md
# game_score

Scoring and difficulty unit directly downstream of the game plate. Consumes the plate's per-check line-elimination report and its lose flag. Maintains a BCD score, a cleared-lines count, the level, and a high score. Derives the gravity period that the opcode-issuing controller uses to pace eMoveDown.

## Interface

Parameters
- digits_p, 6: BCD digits of score and high score.
- lines_per_level_p, 10: cleared lines per level step.
- level_max_p, 15: level saturation value; level_o is 4 bits wide.
- base_period_p, 48: gravity period at level 0, in ticks.
- period_step_p, 3: period decrement per level.
- period_min_p, 2: gravity period floor.

Ports (one clock; reset is asynchronous and active-high)
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous active-high reset.
- clear_i, input, 1: new game. Synchronous.
- lines_i, input, 3: number of lines eliminated by the last check.
- lines_v_i, input, 1: single-cycle strobe qualifying lines_i.
- lose_i, input, 1: level-sensitive lose flag.
- busy_o, output, 1: score update in progress.
- overflow_o, output, 1: sticky; an elimination report was dropped.
- game_over_o, output, 1: game is in state eOver.
- score_bcd_o, output, 4*digits_p: current score, BCD, MSD first.
- high_score_bcd_o, output, 4*digits_p: best score, BCD.
- lines_o, output, 10: total cleared lines, binary, saturates at 999.
- level_o, output, 4: current level.
- gravity_period_o, output, 8: ticks between gravity steps.

## Operation

- FSM states: eIdle, eAdd, eFinal, eOver.
- Reset value of every output is 0, except gravity_period_o = base_period_p. Reset clears the high score.
- clear_i has priority over all events except reset. It zeroes score, lines, level, pending entry, and overflow, and forces eIdle. The high score is kept.
- Report acceptance: lines_v_i with lines_i = 0 is ignored. Values 5 to 7 are treated as 4.
- Point base per report: 1 line = 40, 2 = 100, 3 = 300, 4 = 1200.
- A report is accepted only in eIdle or eAdd. In eFinal and eOver, lines_v_i is ignored.
- eIdle, on an accepted report:
  - Latch base = B and add count = level_o + 1. The level is sampled before this report's lines are added.
  - Add lines to the lines counter. Each time the within-level counter wraps past lines_per_level_p - 1, level increments, saturating at level_max_p.
  - Go to eAdd.
- eAdd:
  - One BCD addition of B per cycle; decrement the count.
  - When the count reaches 0, go to eIdle, or start the pending entry if one is held.
  - Score saturates at all-9s. Once saturated, further additions leave it unchanged.
- Pending buffer: one entry. A report accepted during eAdd fills it. A report arriving while the entry is full is dropped and sets overflow_o.
- Lose handling:
  - Sampled on the rising edge of lose_i.
  - If the FSM is busy, the remaining adds and the pending entry complete first.
  - The FSM then enters eFinal for one cycle. There, high_score takes score if score > high_score; packed BCD compares as unsigned.
  - Then eOver, which holds until clear_i.
- gravity_period_o = max(base_period_p - level*period_step_p, period_min_p). It is registered and updates the cycle after level changes.

## Timing

- Report strobed at cycle t in eIdle: busy_o is high from t+1 to t+level+1 inclusive.
- The first score update is visible at t+2; the final one at t+level+2.
- lines_o and level_o update at t+1.
- A pending entry starts in the cycle after the last add. There is no idle bubble; busy_o stays high.
- lines_v_i in the same cycle as clear_i: the report is discarded.
- lose_i rising in the same cycle as lines_v_i: the report is accepted and scored before eFinal.
- Reset asserted mid-eAdd: outputs go to their reset values immediately. The partial sum is lost.

## Configuration

- SCORE_HIGH_SCORE_EN defined: high-score register and eFinal compare are present.
- SCORE_HIGH_SCORE_EN undefined:
  - high_score_bcd_o is tied to 0 and no register is built.
  - eFinal still exists but performs no compare. The eOver transition timing is identical.

## Structure

- Package tetris gains:
  - score_state_e for the four states.
  - line_points_c, a 4-entry BCD constant array holding 40/100/300/1200.
  - lines_max_c = 999.
- Sub-module bcd_add:
  - Combinational ripple adder of digits_p digits.
  - Ports: operand a, operand b, sum, carry out.
  - Carry out signals saturation.

## Test plan

- Level 0, lines_i = 1 strobe → one busy cycle; score_bcd_o = 000040; lines_o = 1.
- Drive lines to 10, then a lines_i = 4 strobe → level_o = 1 at that strobe; score increases by 2400 over 2 add cycles; gravity_period_o = 45.
- Two strobes 1 cycle apart at level 3 → second is pending, third strobe sets overflow_o; final score delta = 4×B1 + 4×B2.
- Score 999000 plus a 4-line report at level 2 → score_bcd_o = 999999; no wrap.
- lose_i rises during eAdd with score 1200 and high score 800 → adds finish, then high_score_bcd_o = 001200; game_over_o = 1; later strobes are ignored. After clear_i: score = 0, high score = 1200.
- Reset pulse during eAdd → all outputs at reset values within the same cycle; gravity_period_o = 48.
